vector_load_buffer: RTL and testbench
=====================================

# vector_load_buffer

Upstream feeder for the dot-product engine. Accepts a byte stream over a valid/ready handshake and stores it in a 16×8 vector memory: bytes 0–7 are vector A, bytes 8–15 are vector B. After a full 16-byte frame it pulses `calc_start`, serves the engine's combinational read port, and blocks new input until `calc_done`.

## Interface
- `DATA_W`, default 8: byte width. Must match the engine's data width.
- `DEPTH`, default 16: frame length and memory depth. Must be a power of two; `ADDR_W = log2(DEPTH)`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  DATA_W  byte to store.
- `in_ready`  out  1  buffer accepts a byte this cycle.
- `clear`  in  1  synchronous abort of a partial frame.
- `rd_addr`  in  ADDR_W  read address from the engine.
- `rd_data`  out  DATA_W  `mem[rd_addr]`, combinational.
- `calc_start`  out  1  one-cycle pulse: frame complete.
- `calc_done`  in  1  one-cycle pulse from the engine: computation finished.
- `busy`  out  1  frame handed to the engine and not yet released.
- `load_count`  out  ADDR_W+1  bytes accepted in the current frame (0..16).

## Operation
- **States:** S_FILL, S_KICK, S_WAIT_CALC.
- **Reset values:**
  - State S_FILL; write pointer 0; `load_count` 0.
  - `calc_start` 0, `busy` 0.
  - All memory entries 0, so `rd_data` is 0 for every address.
  - `in_ready` is 1 immediately after reset.
- **`in_ready`** is a pure decode of the state register: `in_ready = (state == S_FILL)`. There is no combinational path from `in_valid` to `in_ready`.
- **S_FILL:**
  - A byte is accepted on an edge where `in_valid && in_ready`.
  - On acceptance: write `mem[wr_ptr] <= in_data`, then increment `wr_ptr` and `load_count`.
  - On the edge that accepts the 16th byte (`wr_ptr == 15`), go to S_KICK.
- **S_KICK:** lasts exactly one cycle, with `calc_start = 1` and `busy = 1`, then go to S_WAIT_CALC.
- **S_WAIT_CALC:**
  - `busy = 1`; `in_valid` is ignored and memory is frozen.
  - On `calc_done`: go to S_FILL, and set `wr_ptr` and `load_count` to 0.
- **Rules that hold in every state:**
  - `calc_start` and `busy` are registered outputs.
  - Reads are allowed in every state. The port is asynchronous, so the engine can sample data the cycle after it drives `rd_addr`.
  - Write pointer wrap: `wr_ptr` never wraps inside a frame. The count saturates at 16 and the pointer is reset on frame release.
- **`clear`:**
  - In S_FILL, `clear` sets `wr_ptr` and `load_count` to 0 and keeps memory contents.
  - If `clear` and an accept occur on the same edge, `clear` wins: the byte is dropped and nothing is written.
  - In S_KICK and S_WAIT_CALC, `clear` is ignored, because the engine is already committed.
- **`calc_done` outside S_WAIT_CALC:** ignored.
- **Reset mid-frame or mid-compute:** immediate return to reset values. The engine is reset by the same `rst`.

## Timing
- Throughput: one byte per cycle while `in_valid` is held high in S_FILL. A full frame takes 16 cycles.
- Latency from the 16th accept edge (edge N):
  - `calc_start` is high during cycle N→N+1.
  - The engine sees `start` at edge N+1.
- Frame release: after the `calc_done` edge, `in_ready` is 1 in the next cycle.
- Read path: `rd_data` reflects a write one edge after the write is accepted. A write and a read to the same address in the same cycle return the old value.

## Configuration
- **`VLB_CHECKSUM_EN` defined:**
  - Adds output `checksum`, width DATA_W.
  - It is the mod-2^DATA_W sum of the bytes accepted in the current frame.
  - It is cleared together with `load_count`: on reset, on `clear`, and on frame release.
  - It holds its value through S_KICK and S_WAIT_CALC.
- **`VLB_CHECKSUM_EN` undefined:** the `checksum` port and its adder are absent. All other behaviour is identical.

## Structure
- **Shared package `vector_pkg`:**
  - State encoding enum: S_FILL, S_KICK, S_WAIT_CALC.
  - `VEC_LEN = 8`, `MEM_DEPTH = 16`, `B_BASE = 8`.
  - `ADDR_W`.
- **One sub-module, `vec_regfile16x8`:**
  - Synchronous write port with async reset to 0.
  - Asynchronous read port.
  - The FSM, pointer and checksum stay in the top level.

## Test plan
- **Reset:** assert `rst` mid-frame after 7 bytes. Required: `in_ready` = 1, `busy` = 0, `load_count` = 0, and `rd_data` = 0x00 for addresses 0 and 15.
- **Full load:** stream bytes 1..16 with `in_valid` held high. Required:
  - 16 accepts in 16 cycles, then a single `calc_start` pulse.
  - `rd_data[0]` = 1, `rd_data[8]` = 9, `rd_data[15]` = 16.
  - `in_ready` = 0.
- **Backpressure:** drive `in_valid` = 1 with 0xFF during S_WAIT_CALC. Required: no write, and `load_count` stays 16. After a `calc_done` pulse: `in_ready` = 1 next cycle and `load_count` = 0.
- **Clear collision:** after 5 bytes, assert `clear` together with `in_valid` (0xAA). Required: `load_count` = 0, 0xAA is not stored, and the next byte is written at address 0.
- **End-to-end with the dot-product engine:**
  - A = 1..8, B = all 1. Required: `done` with result 36 (0x24).
  - Next frame A = B = all 16. Required: result 0x00, the low byte of 2048.
- **Checksum (`VLB_CHECKSUM_EN`):**
  - Bytes 1..16: `checksum` = 0x88.
  - 16 × 0xFF: `checksum` = 0xF0.
  - After `clear`: `checksum` = 0x00.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared definitions for the vector load buffer: state encoding and frame geometry.
package vector_pkg;

  typedef enum logic [1:0] {
    S_FILL      = 2'd0,
    S_KICK      = 2'd1,
    S_WAIT_CALC = 2'd2
  } state_t;

  localparam int VEC_LEN   = 8;
  localparam int MEM_DEPTH = 16;
  localparam int B_BASE    = 8;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);

endpackage

// File: rtl/vec_regfile16x8.sv
// Vector memory: one synchronous write port, one asynchronous read port, async reset to 0.
module vec_regfile16x8 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vector_load_buffer.sv
// Byte-stream loader for the dot-product engine: fills a 16-entry frame, kicks the engine, waits for done.
// Optional running byte checksum output when VLB_CHECKSUM_EN is defined.
module vector_load_buffer
  import vector_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = MEM_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              calc_start,
  input  logic              calc_done,
  output logic              busy,
  output logic [AW:0]       load_count
`ifdef VLB_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic          wr_en;

  assign in_ready = (state == S_FILL);
  // clear has priority over an accept on the same edge
  assign wr_en    = in_ready && in_valid && !clear;

  vec_regfile16x8 #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FILL;
      wr_ptr     <= '0;
      load_count <= '0;
      calc_start <= 1'b0;
      busy       <= 1'b0;
`ifdef VLB_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      case (state)
        S_FILL: begin
          if (clear) begin
            wr_ptr     <= '0;
            load_count <= '0;
`ifdef VLB_CHECKSUM_EN
            checksum   <= '0;
`endif
          end else if (in_valid) begin
            load_count <= load_count + (AW+1)'(1);
`ifdef VLB_CHECKSUM_EN
            checksum   <= checksum + in_data;
`endif
            // pointer parks on the last slot until the frame is released
            if (wr_ptr == AW'(DEPTH-1)) begin
              state      <= S_KICK;
              calc_start <= 1'b1;
              busy       <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + AW'(1);
            end
          end
        end
        S_KICK: begin
          calc_start <= 1'b0;
          state      <= S_WAIT_CALC;
        end
        S_WAIT_CALC: begin
          if (calc_done) begin
            state      <= S_FILL;
            busy       <= 1'b0;
            wr_ptr     <= '0;
            load_count <= '0;
`ifdef VLB_CHECKSUM_EN
            checksum   <= '0;
`endif
          end
        end
        default: begin
          state      <= S_FILL;
          calc_start <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_buffer.sv
// Scoreboard bench for vector_load_buffer; exercises checksum when VLB_CHECKSUM_EN is defined.
module tb_vector_load_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       clear = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       calc_start;
  logic       calc_done = 1'b0;
  logic       busy;
  logic [4:0] load_count;
`ifdef VLB_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } sb_t;
  sb_t        sb_q[$];
  logic [7:0] exp_mem [16];
  logic [7:0] frame_buf [16];
  int         m_ptr = 0;
  logic [7:0] m_sum = '0;

  always #5 clk = ~clk;

  vector_load_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .clear      (clear),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .calc_start (calc_start),
    .calc_done  (calc_done),
    .busy       (busy),
    .load_count (load_count)
`ifdef VLB_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    sb_q.delete();
    m_ptr = 0;
    m_sum = '0;
  endtask

  // Drive one accepted byte in S_FILL and record it in the scoreboard.
  task automatic send_byte(input logic [7:0] b);
    sb_t e;
    in_valid = 1'b1;
    in_data  = b;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready ptr=%0d got in_ready=%b want 1", m_ptr, in_ready);
    end
    tick();
    in_valid = 1'b0;
    e.addr = 4'(m_ptr);
    e.data = b;
    sb_q.push_back(e);
    exp_mem[m_ptr] = b;
    m_sum = m_sum + b;
    if (m_ptr < 15) m_ptr++;
  endtask

  task automatic drain_scoreboard(input string tag);
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rd_addr = e.addr;
      #1;
      vectors++;
      if (rd_data !== e.data) begin
        miscompares++;
        $display("FAIL %s rd_data[%0d] got %h want %h", tag, e.addr, rd_data, e.data);
      end
    end
  endtask

  // Stream frame_buf back to back; calc_start must be high right after the 16th edge.
  task automatic send_frame(input string tag);
    int pulses = 0;
    for (int i = 0; i < 16; i++) send_byte(frame_buf[i]);
    vectors++;
    if (calc_start !== 1'b1 || busy !== 1'b1 || load_count !== 5'd16) begin
      miscompares++;
      $display("FAIL %s kick got start=%b busy=%b cnt=%0d want 1 1 16", tag, calc_start, busy, load_count);
    end
    pulses = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (calc_start === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s pulse got pulses=%0d in_ready=%b busy=%b want 1 0 1", tag, pulses, in_ready, busy);
    end
  endtask

  task automatic release_frame(input string tag);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    m_ptr = 0;
    m_sum = '0;
    vectors++;
    if (in_ready !== 1'b1 || load_count !== 5'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release got in_ready=%b cnt=%0d busy=%b want 1 0 0", tag, in_ready, load_count, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || load_count !== 5'd0 || calc_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_init got rdy=%b busy=%b cnt=%0d start=%b want 1 0 0 0", in_ready, busy, load_count, calc_start);
    end
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + i));
    vectors++;
    if (load_count !== 5'd7) begin
      miscompares++;
      $display("FAIL reset_premid cnt got %0d want 7", load_count);
    end
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || load_count !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_mid got rdy=%b busy=%b cnt=%0d want 1 0 0", in_ready, busy, load_count);
    end
    rd_addr = 4'd0;
    #1;
    vectors++;
    if (rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mem0 got %h want 00", rd_data);
    end
    rd_addr = 4'd15;
    #1;
    vectors++;
    if (rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mem15 got %h want 00", rd_data);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i + 1);
    send_frame("full_load");
    rd_addr = 4'd0;  #1;
    vectors++;
    if (rd_data !== 8'd1) begin miscompares++; $display("FAIL full_mem0 got %0d want 1", rd_data); end
    rd_addr = 4'd8;  #1;
    vectors++;
    if (rd_data !== 8'd9) begin miscompares++; $display("FAIL full_mem8 got %0d want 9", rd_data); end
    rd_addr = 4'd15; #1;
    vectors++;
    if (rd_data !== 8'd16) begin miscompares++; $display("FAIL full_mem15 got %0d want 16", rd_data); end
    drain_scoreboard("full_load");
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    clear    = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    vectors++;
    if (load_count !== 5'd16 || in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_hold got cnt=%0d rdy=%b busy=%b want 16 0 1", load_count, in_ready, busy);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      vectors++;
      if (rd_data !== exp_mem[i]) begin
        miscompares++;
        $display("FAIL bp_frozen rd_data[%0d] got %h want %h", i, rd_data, exp_mem[i]);
      end
    end
    release_frame("backpressure");
    // calc_done in S_FILL must be ignored
    send_byte(8'h21);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    vectors++;
    if (load_count !== 5'd1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL done_in_fill got cnt=%0d rdy=%b want 1 1", load_count, in_ready);
    end
    drain_scoreboard("done_in_fill");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_ptr = 0;
    m_sum = '0;
  endtask

  task automatic test_clear_collision();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i));
    vectors++;
    if (load_count !== 5'd5) begin
      miscompares++;
      $display("FAIL clr_pre cnt got %0d want 5", load_count);
    end
    drain_scoreboard("clr_pre");
    in_valid = 1'b1;
    in_data  = 8'hAA;
    clear    = 1'b1;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    m_ptr = 0;
    m_sum = '0;
    vectors++;
    if (load_count !== 5'd0) begin
      miscompares++;
      $display("FAIL clr_count got %0d want 0", load_count);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      vectors++;
      if (rd_data !== exp_mem[i]) begin
        miscompares++;
        $display("FAIL clr_nowrite rd_data[%0d] got %h want %h", i, rd_data, exp_mem[i]);
      end
    end
    send_byte(8'h55);
    vectors++;
    if (load_count !== 5'd1) begin
      miscompares++;
      $display("FAIL clr_next cnt got %0d want 1", load_count);
    end
    drain_scoreboard("clr_next");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_ptr = 0;
    m_sum = '0;
  endtask

  // Bench-side engine: reads A and B through rd_addr and accumulates the low byte of the dot product.
  task automatic run_engine(input logic [7:0] want, input string tag);
    logic [7:0] a, b, acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 4'(i);      #1; a = rd_data;
      rd_addr = 4'(i + 8);  #1; b = rd_data;
      acc = acc + 8'(a * b);
    end
    vectors++;
    if (acc !== want) begin
      miscompares++;
      $display("FAIL %s result got %h want %h", tag, acc, want);
    end
  endtask

  task automatic test_end_to_end();
    for (int i = 0; i < 8; i++) begin
      frame_buf[i]     = 8'(i + 1);
      frame_buf[i + 8] = 8'd1;
    end
    send_frame("e2e1");
    drain_scoreboard("e2e1");
    run_engine(8'h24, "e2e1");
    release_frame("e2e1");
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'd16;
    send_frame("e2e2");
    drain_scoreboard("e2e2");
    run_engine(8'h00, "e2e2");
    release_frame("e2e2");
  endtask

`ifdef VLB_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i + 1);
    send_frame("csum1");
    vectors++;
    if (checksum !== 8'h88 || checksum !== m_sum) begin
      miscompares++;
      $display("FAIL csum_1to16 got %h want 88", checksum);
    end
    sb_q.delete();
    release_frame("csum1");
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'hFF;
    send_frame("csum2");
    vectors++;
    if (checksum !== 8'hF0) begin
      miscompares++;
      $display("FAIL csum_ff got %h want f0", checksum);
    end
    sb_q.delete();
    release_frame("csum2");
    for (int i = 0; i < 3; i++) send_byte(8'h07);
    vectors++;
    if (checksum !== 8'h15) begin
      miscompares++;
      $display("FAIL csum_partial got %h want 15", checksum);
    end
    sb_q.delete();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_ptr = 0;
    m_sum = '0;
    vectors++;
    if (checksum !== 8'h00) begin
      miscompares++;
      $display("FAIL csum_clear got %h want 00", checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_clear_collision();
    test_end_to_end();
`ifdef VLB_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
